// File: rtl/playback_scheduler_if.sv
// Command/status bundle between mode logic (master) and playback_scheduler (slave).
//   master drives: start, stop, pause, next, prev, repeat_en, song_sel, track_len, note_over
//   slave drives : song_id, note_idx, snd_en, busy, song_done, state
interface playback_scheduler_if #(
  parameter int unsigned SONG_BITS = 3,
  parameter int unsigned CNT_BITS  = 8
);
  logic                 start;
  logic                 stop;
  logic                 pause;
  logic                 next;
  logic                 prev;
  logic                 repeat_en;
  logic [SONG_BITS-1:0] song_sel;
  logic [CNT_BITS-1:0]  track_len;
  logic                 note_over;
  logic [SONG_BITS-1:0] song_id;
  logic [CNT_BITS-1:0]  note_idx;
  logic                 snd_en;
  logic                 busy;
  logic                 song_done;
  logic [2:0]           state;

  modport master (
    output start, stop, pause, next, prev, repeat_en, song_sel, track_len, note_over,
    input  song_id, note_idx, snd_en, busy, song_done, state
  );

  modport slave (
    input  start, stop, pause, next, prev, repeat_en, song_sel, track_len, note_over,
    output song_id, note_idx, snd_en, busy, song_done, state
  );
endinterface

// File: rtl/playback_scheduler.sv
// Song/note sequencer for the note-playing engine: selects song and note index in
// the song ROM, gates the engine enable, inserts inter-note gaps and handles
// start/stop/pause/next/prev/repeat commands.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries commands in
// and song_id/note_idx/snd_en/busy/song_done/state out, all registered.
module playback_scheduler #(
  parameter int unsigned SONG_BITS  = 3,
  parameter int unsigned NUM_SONGS  = 4,
  parameter int unsigned CNT_BITS   = 8,
  parameter int unsigned GAP_CYCLES = 5000000
) (
  input logic                  clk,
  input logic                  rst_n,
  playback_scheduler_if.slave  bus
);

  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [SONG_BITS-1:0] SONG_FIRST = SONG_BITS'(1);
  localparam logic [SONG_BITS-1:0] SONG_LAST  = SONG_BITS'(NUM_SONGS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_GAP   = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  // After a note: silent gap, or straight to the next note when the gap is disabled
  localparam state_t ADV_ST = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

  state_t               state_q, state_d;
  logic [SONG_BITS-1:0] song_id_q, song_id_d;
  logic [CNT_BITS-1:0]  note_idx_q, note_idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 snd_en_q, busy_q, done_q, done_d;

  logic                 sel_valid_c;
  logic [SONG_BITS-1:0] song_inc_c, song_dec_c;

  assign sel_valid_c = (bus.song_sel != '0) && (bus.song_sel <= SONG_LAST);
  assign song_inc_c  = (song_id_q >= SONG_LAST)  ? SONG_FIRST : song_id_q + SONG_BITS'(1);
  assign song_dec_c  = (song_id_q <= SONG_FIRST) ? SONG_LAST  : song_id_q - SONG_BITS'(1);

  // Next-state and datapath updates; commands are resolved by priority before note_over
  always_comb begin
    state_d    = state_q;
    song_id_d  = song_id_q;
    note_idx_d = note_idx_q;
    gap_d      = '0;
    done_d     = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.start && sel_valid_c) begin
        song_id_d  = bus.song_sel;
        note_idx_d = '0;
        state_d    = S_LOAD;
      end
    end else if (bus.stop) begin
      state_d    = S_IDLE;
      song_id_d  = '0;
      note_idx_d = '0;
    end else if (bus.start) begin
      // Invalid restart request behaves as stop
      song_id_d  = sel_valid_c ? bus.song_sel : '0;
      note_idx_d = '0;
      state_d    = sel_valid_c ? S_LOAD : S_IDLE;
    end else if (bus.next) begin
      song_id_d  = song_inc_c;
      note_idx_d = '0;
      state_d    = bus.pause ? S_PAUSE : S_LOAD;
    end else if (bus.prev) begin
      // Mid-song prev rewinds; at the first note it steps back a song
      if (note_idx_q == '0) song_id_d = song_dec_c;
      note_idx_d = '0;
      state_d    = bus.pause ? S_PAUSE : S_LOAD;
    end else begin
      unique case (state_q)
        S_LOAD:  state_d = bus.pause ? S_PAUSE : S_PLAY;
        S_PLAY: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (bus.note_over) begin
            if (note_idx_q < bus.track_len) begin
              note_idx_d = note_idx_q + CNT_BITS'(1);
              state_d    = ADV_ST;
            end else if (bus.repeat_en) begin
              note_idx_d = '0;
              state_d    = ADV_ST;
            end else begin
              done_d     = 1'b1;
              song_id_d  = '0;
              note_idx_d = '0;
              state_d    = S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (gap_q == GAP_W'(GAP_LAST)) begin
            state_d = S_LOAD;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        S_PAUSE: if (!bus.pause) state_d = S_LOAD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      song_id_q  <= '0;
      note_idx_q <= '0;
      gap_q      <= '0;
      snd_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_id_q  <= song_id_d;
      note_idx_q <= note_idx_d;
      gap_q      <= gap_d;
      snd_en_q   <= (state_d == S_PLAY);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.song_id   = song_id_q;
  assign bus.note_idx  = note_idx_q;
  assign bus.snd_en    = snd_en_q;
  assign bus.busy      = busy_q;
  assign bus.song_done = done_q;

endmodule

// File: tb/tb_playback_scheduler.sv
// Scoreboard bench for playback_scheduler: stimulus pushes expected events
// (note start, song done, return to idle); a negedge monitor pops and compares.
module tb_playback_scheduler;

  localparam int unsigned SB = 3;
  localparam int unsigned CB = 8;
  localparam int unsigned GAP = 4;

  localparam int EV_NOTE = 1;
  localparam int EV_DONE = 2;
  localparam int EV_IDLE = 3;

  typedef struct {
    int kind;
    int sid;
    int idx;
  } ev_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  ev_t  exp_q[$];

  playback_scheduler_if #(.SONG_BITS(SB), .CNT_BITS(CB)) bus ();

  playback_scheduler #(
    .SONG_BITS(SB), .NUM_SONGS(4), .CNT_BITS(CB), .GAP_CYCLES(GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int sid, input int idx);
    ev_t e;
    e.kind = kind;
    e.sid  = sid;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  // Monitor: turns DUT output changes into events and compares with the queue head
  logic prev_snd, prev_busy;

  task automatic observe(input int kind);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d song %0d idx %0d, queue empty at %0t",
               kind, bus.song_id, bus.note_idx, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.sid != int'(bus.song_id) || e.idx != int'(bus.note_idx)) begin
        n_err++;
        $display("FAIL event: got kind %0d song %0d idx %0d expected kind %0d song %0d idx %0d at %0t",
                 kind, bus.song_id, bus.note_idx, e.kind, e.sid, e.idx, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_snd  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (bus.snd_en && !prev_snd) observe(EV_NOTE);
      if (bus.song_done)           observe(EV_DONE);
      if (!bus.busy && prev_busy)  observe(EV_IDLE);
      prev_snd  = bus.snd_en;
      prev_busy = bus.busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_snd(output int k);
    k = 0;
    while (!bus.snd_en && k < 50) begin
      cyc(1);
      k++;
    end
  endtask

  // Start a valid song and check the two-cycle start latency
  task automatic start_song(input int sel);
    push(EV_NOTE, sel, 0);
    bus.song_sel = SB'(sel);
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    check("load_snd_en", int'(bus.snd_en), 0);
    cyc(1);
    check("start_latency", int'(bus.snd_en), 1);
  endtask

  // Finish the current note and expect the next one after the gap
  task automatic play_note(input int sid, input int nxt);
    int k;
    push(EV_NOTE, sid, nxt);
    bus.note_over = 1'b1; cyc(1); bus.note_over = 1'b0;
    wait_snd(k);
    check("gap_cycles", k, GAP + 1);
    check("note_idx", int'(bus.note_idx), nxt);
  endtask

  task automatic end_song();
    push(EV_DONE, 0, 0);
    push(EV_IDLE, 0, 0);
    bus.note_over = 1'b1; cyc(1); bus.note_over = 1'b0;
    check("done_pulse", int'(bus.song_done), 1);
    check("done_busy", int'(bus.busy), 0);
    check("done_song_id", int'(bus.song_id), 0);
    cyc(1);
    check("done_one_cycle", int'(bus.song_done), 0);
  endtask

  task automatic stop_song();
    push(EV_IDLE, 0, 0);
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    check("stop_state", int'(bus.state), 0);
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.next = 0; bus.prev = 0;
    bus.repeat_en = 0; bus.song_sel = '0; bus.track_len = CB'(3); bus.note_over = 0;

    // Reset
    cyc(3);
    check("rst_state", int'(bus.state), 0);
    check("rst_song_id", int'(bus.song_id), 0);
    check("rst_note_idx", int'(bus.note_idx), 0);
    check("rst_snd_en", int'(bus.snd_en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.song_done), 0);
    rst_n = 1'b1;
    cyc(2);

    // Invalid starts and stray commands in IDLE are ignored
    bus.song_sel = SB'(0); bus.start = 1; cyc(1); bus.start = 0; cyc(2);
    check("idle_sel0", int'(bus.busy), 0);
    bus.song_sel = SB'(5); bus.start = 1; cyc(1); bus.start = 0; cyc(2);
    check("idle_sel5", int'(bus.state), 0);
    bus.next = 1; bus.note_over = 1; cyc(1); bus.next = 0; bus.note_over = 0; cyc(2);
    check("idle_next", int'(bus.state), 0);

    // Full song 2 without repeat: notes 0..3 then done
    start_song(2);
    play_note(2, 1);
    play_note(2, 2);
    play_note(2, 3);
    end_song();

    // Repeat: wraps to note 0 with no done, then stop
    bus.repeat_en = 1;
    start_song(2);
    play_note(2, 1);
    play_note(2, 2);
    play_note(2, 3);
    play_note(2, 0);
    check("repeat_busy", int'(bus.busy), 1);
    stop_song();
    bus.repeat_en = 0;

    // Pause mid-note at note 1
    start_song(1);
    play_note(1, 1);
    bus.pause = 1; cyc(1);
    check("pause_snd_en", int'(bus.snd_en), 0);
    check("pause_state", int'(bus.state), 4);
    cyc(100);
    check("pause_hold_idx", int'(bus.note_idx), 1);
    check("pause_hold_state", int'(bus.state), 4);
    push(EV_NOTE, 1, 1);
    bus.pause = 0; cyc(1);
    check("resume_load", int'(bus.state), 1);
    cyc(1);
    check("resume_play", int'(bus.state), 2);
    check("resume_idx", int'(bus.note_idx), 1);
    // Invalid restart while busy acts as stop
    push(EV_IDLE, 0, 0);
    bus.song_sel = SB'(7); bus.start = 1; cyc(1); bus.start = 0;
    check("bad_restart", int'(bus.state), 0);

    // Skip and wrap on song 4
    start_song(4);
    play_note(4, 1);
    play_note(4, 2);
    push(EV_NOTE, 1, 0);
    bus.next = 1; cyc(1); bus.next = 0;
    check("next_wrap_id", int'(bus.song_id), 1);
    check("next_idx", int'(bus.note_idx), 0);
    cyc(1);
    push(EV_NOTE, 4, 0);
    bus.prev = 1; cyc(1); bus.prev = 0;
    check("prev_wrap_id", int'(bus.song_id), 4);
    cyc(1);
    push(EV_NOTE, 3, 0);
    bus.prev = 1; cyc(1); bus.prev = 0;
    check("prev_dec_id", int'(bus.song_id), 3);
    cyc(1);
    play_note(3, 1);
    push(EV_NOTE, 3, 0);
    bus.prev = 1; cyc(1); bus.prev = 0;
    check("prev_rewind_id", int'(bus.song_id), 3);
    check("prev_rewind_idx", int'(bus.note_idx), 0);
    cyc(1);

    // Collision: note_over with stop
    push(EV_IDLE, 0, 0);
    bus.note_over = 1; bus.stop = 1; cyc(1); bus.note_over = 0; bus.stop = 0;
    check("coll_state", int'(bus.state), 0);
    check("coll_idx", int'(bus.note_idx), 0);
    check("coll_done", int'(bus.song_done), 0);
    cyc(2);

    // Single-note song (track_len 0)
    bus.track_len = CB'(0);
    start_song(1);
    end_song();
    bus.track_len = CB'(3);

    // Async reset in the middle of a gap
    start_song(2);
    bus.note_over = 1; cyc(1); bus.note_over = 0;
    cyc(1);
    check("gap_state", int'(bus.state), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", int'(bus.state), 0);
    check("arst_snd_en", int'(bus.snd_en), 0);
    check("arst_song_id", int'(bus.song_id), 0);
    check("arst_busy", int'(bus.busy), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    check("post_rst_idle", int'(bus.state), 0);
    check("post_rst_snd", int'(bus.snd_en), 0);

    wait_snd(k);
    check("post_rst_no_play", k, 50);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
